// File: rtl/tomasulo_pkg.sv
// Shared constants, opcode names and instruction field helpers for the
// Tomasulo retire path.
package tomasulo_pkg;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned DW       = 16;
  localparam int unsigned TAG_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = TAG_W + 1;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned PC_W     = 4;
  localparam int unsigned FUNC_W   = 4;

  // Instruction layout: {func[15:12], rs1/addr_hi[11:8], rs2/addr_lo[7:4], rd/imm[3:0]}
  localparam int unsigned FUNC_LSB = 12;
  localparam int unsigned ADDR_LSB = 4;
  localparam int unsigned RD_LSB   = 0;

  // Encodings 1000-1111 are reserved and retire without side effects.
  typedef enum logic [FUNC_W-1:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_MUL   = 4'h2,
    OP_DIV   = 4'h3,
    OP_LOAD  = 4'h4,
    OP_STORE = 4'h5,
    OP_BEQ   = 4'h6,
    OP_BNEQ  = 4'h7
  } opcode_t;

  function automatic logic [FUNC_W-1:0] inst_func(input logic [DW-1:0] inst);
    return inst[FUNC_LSB +: FUNC_W];
  endfunction

  function automatic logic [REG_W-1:0] inst_rd(input logic [DW-1:0] inst);
    return inst[RD_LSB +: REG_W];
  endfunction

  function automatic logic [ADDR_W-1:0] inst_addr(input logic [DW-1:0] inst);
    return inst[ADDR_LSB +: ADDR_W];
  endfunction

  function automatic logic [PC_W-1:0] inst_imm(input logic [DW-1:0] inst);
    return inst[RD_LSB +: PC_W];
  endfunction

endpackage

// File: rtl/rob_ptr_ctr.sv
// Wrapping ROB pointer (head or tail).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, pointer -> 0
//   inc   : advance by one, wrapping at 2**W
//   clr   : return to 0 (wins over inc)
//   ptr   : current pointer value
module rob_ptr_ctr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retire stage of the reorder buffer.
//   clk1/rst_n                : clock, asynchronous active-low reset
//   alloc_valid/inst/ready/tag: issue-side allocation handshake (tag = tail)
//   cdb_valid/tag/value       : result broadcast into the entry array
//   qry_tag/ready/value       : combinational operand-forwarding lookup
//   rf_*                      : registered register-bank write (rf_we pulses)
//   mem_*                     : registered store commit (mem_we pulses)
//   flush/redirect_pc         : registered taken-branch flush pulse and target
//   rob_count                 : occupied entries, 0..DEPTH
module rob_commit_unit
  import tomasulo_pkg::*;
(
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [DW-1:0]     alloc_inst,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DW-1:0]     cdb_value,
  input  logic [TAG_W-1:0]  qry_tag,
  output logic              qry_ready,
  output logic [DW-1:0]     qry_value,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_addr,
  output logic [DW-1:0]     rf_data,
  output logic [TAG_W-1:0]  rf_tag,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_data,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  rob_count
);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_ready;
  logic [DW-1:0]    ent_inst  [DEPTH];
  logic [DW-1:0]    ent_value [DEPTH];

  logic [CNT_W-1:0] count;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  logic             alloc_fire;
  logic             commit_fire;
  logic             taken;
  logic             cdb_hit;
  logic [DW-1:0]    head_inst;
  logic [DW-1:0]    head_value;
  logic [FUNC_W-1:0] head_func;

  // Full check uses the registered count only, so a retiring head never
  // opens a slot in the same cycle.
  assign alloc_ready = (count != CNT_W'(DEPTH));
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid & alloc_ready;

  assign head_inst   = ent_inst[head];
  assign head_value  = ent_value[head];
  assign head_func   = inst_func(head_inst);
  assign commit_fire = ent_valid[head] & ent_ready[head];
  assign taken       = commit_fire & head_value[0] &
                       ((head_func == OP_BEQ) | (head_func == OP_BNEQ));

  // The slot being allocated is still invalid this cycle, so a broadcast to
  // it is dropped; the explicit tail compare keeps that independent of order.
  assign cdb_hit = cdb_valid & ent_valid[cdb_tag] & ~(alloc_fire & (cdb_tag == tail));

  assign qry_ready = ent_valid[qry_tag] & ent_ready[qry_tag];
  assign qry_value = ent_value[qry_tag];
  assign rob_count = count;

  rob_ptr_ctr #(.W(TAG_W)) u_head (
    .clk   (clk1),
    .rst_n (rst_n),
    .inc   (commit_fire),
    .clr   (taken),
    .ptr   (head)
  );

  rob_ptr_ctr #(.W(TAG_W)) u_tail (
    .clk   (clk1),
    .rst_n (rst_n),
    .inc   (alloc_fire),
    .clr   (taken),
    .ptr   (tail)
  );

  // Entry status and occupancy. A taken branch empties the window and
  // discards whatever allocation or broadcast arrived alongside it.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      ent_ready <= '0;
      count     <= '0;
    end else if (taken) begin
      ent_valid <= '0;
      ent_ready <= '0;
      count     <= '0;
    end else begin
      if (cdb_hit) ent_ready[cdb_tag] <= 1'b1;
      if (commit_fire) begin
        ent_valid[head] <= 1'b0;
        ent_ready[head] <= 1'b0;
      end
      if (alloc_fire) begin
        ent_valid[tail] <= 1'b1;
        ent_ready[tail] <= 1'b0;
      end
      count <= count + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    end
  end

  // Payload storage; meaningful only while the matching valid bit is set.
  always_ff @(posedge clk1) begin
    if (alloc_fire && !taken) ent_inst[tail]     <= alloc_inst;
    if (cdb_hit && !taken)    ent_value[cdb_tag] <= cdb_value;
  end

  // Commit decode into registered outputs: strobes pulse, data fields hold.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rf_we       <= 1'b0;
      rf_addr     <= '0;
      rf_data     <= '0;
      rf_tag      <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      rf_we  <= 1'b0;
      mem_we <= 1'b0;
      flush  <= 1'b0;
      if (commit_fire) begin
        case (head_func)
          OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LOAD: begin
            rf_we   <= 1'b1;
            rf_addr <= inst_rd(head_inst);
            rf_data <= head_value;
            rf_tag  <= head;
          end
          OP_STORE: begin
            mem_we   <= 1'b1;
            mem_addr <= inst_addr(head_inst);
            mem_data <= head_value;
          end
          OP_BEQ, OP_BNEQ: begin
            if (head_value[0]) begin
              flush       <= 1'b1;
              redirect_pc <= inst_imm(head_inst);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
